// File: rtl/odd_result_pipe.sv
// Staging/writeback pipeline behind the odd-pipe execution unit: carries each
// result through NUM_STAGES registers, answers forwarding queries, writes back.
module odd_result_pipe #(
    parameter int NUM_STAGES = 7,
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [0:DATA_W-1] in_rt_value,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic              in_reg_write,
    input  logic [3:0]        in_unit_latency,
    input  logic [2:0]        in_unit_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] fwd_query_addr,
    output logic              fwd_hit,
    output logic [0:DATA_W-1] fwd_value,
    output logic              fwd_pending,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [0:DATA_W-1] wb_value,
    output logic [2:0]        wb_unit_id,
    output logic [2:0]        in_flight
);

    localparam int LAT_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES:1] st_valid;
    logic [NUM_STAGES:1] st_wr;
    logic [0:DATA_W-1]   st_value [1:NUM_STAGES];
    logic [ADDR_W-1:0]   st_addr  [1:NUM_STAGES];
    logic [LAT_W-1:0]    st_lat   [1:NUM_STAGES];
    logic [2:0]          st_id    [1:NUM_STAGES];

    logic [NUM_STAGES:1] nxt_valid;
    logic [LAT_W-1:0]    cap_lat;
    int                  nxt_count;

    logic                match_found;
    logic                match_ready;
    logic [0:DATA_W-1]   match_value;

    // Latencies outside 1..NUM_STAGES are clamped so every packet becomes ready somewhere.
    always_comb begin
        if (in_unit_latency == 4'd0)
            cap_lat = LAT_W'(1);
        else if (int'(in_unit_latency) > NUM_STAGES)
            cap_lat = LAT_W'(NUM_STAGES);
        else
            cap_lat = LAT_W'(in_unit_latency);
    end

    always_comb begin
        nxt_valid = '0;
        nxt_count = 0;
        if (!reset) begin
            nxt_valid[1] = in_valid & ~flush;
            for (int k = 2; k <= NUM_STAGES; k++)
                nxt_valid[k] = st_valid[k-1];
        end
        for (int k = 1; k <= NUM_STAGES; k++)
            nxt_count = nxt_count + int'(nxt_valid[k]);
    end

    always_ff @(posedge clock) begin
        st_valid  <= nxt_valid;
        in_flight <= 3'(nxt_count);
    end

    always_ff @(posedge clock) begin
        st_value[1] <= in_rt_value;
        st_addr[1]  <= in_rt_addr;
        st_wr[1]    <= in_reg_write;
        st_lat[1]   <= cap_lat;
        st_id[1]    <= in_unit_id;
        for (int k = 2; k <= NUM_STAGES; k++) begin
            st_value[k] <= st_value[k-1];
            st_addr[k]  <= st_addr[k-1];
            st_wr[k]    <= st_wr[k-1];
            st_lat[k]   <= st_lat[k-1];
            st_id[k]    <= st_id[k-1];
        end
    end

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        match_found = 1'b0;
        match_ready = 1'b0;
        match_value = '0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (st_valid[k] && st_wr[k] && st_addr[k] == fwd_query_addr) begin
                match_found = 1'b1;
                match_ready = (k >= int'(st_lat[k]));
                match_value = st_value[k];
            end
        end
    end

    assign fwd_hit     = match_found & match_ready;
    assign fwd_pending = match_found & ~match_ready;
    assign fwd_value   = (match_found && match_ready) ? match_value : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_value   <= '0;
            wb_unit_id <= '0;
        end else begin
            wb_valid <= st_valid[NUM_STAGES] & st_wr[NUM_STAGES];
            if (st_valid[NUM_STAGES] && st_wr[NUM_STAGES]) begin
                wb_addr    <= st_addr[NUM_STAGES];
                wb_value   <= st_value[NUM_STAGES];
                wb_unit_id <= st_id[NUM_STAGES];
            end
        end
    end

endmodule

// File: tb/tb_odd_result_pipe.sv
// Scoreboard bench for odd_result_pipe: cycle-indexed packet history model,
// writeback expectations queued at issue and checked by a negedge monitor.
module tb_odd_result_pipe;

    localparam int NS  = 7;
    localparam int BIG = 1 << 30;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [0:127] in_rt_value;
    logic [6:0]   in_rt_addr;
    logic         in_reg_write;
    logic [3:0]   in_unit_latency;
    logic [2:0]   in_unit_id;
    logic         flush;
    logic [6:0]   fwd_query_addr;
    logic         fwd_hit;
    logic [0:127] fwd_value;
    logic         fwd_pending;
    logic         wb_valid;
    logic [6:0]   wb_addr;
    logic [0:127] wb_value;
    logic [2:0]   wb_unit_id;
    logic [2:0]   in_flight;

    typedef struct {
        int           issue;
        int           killed;
        logic [6:0]   addr;
        logic [0:127] value;
        bit           wr;
        int           lat;
    } pkt_t;

    typedef struct {
        int           due;
        logic [6:0]   addr;
        logic [0:127] value;
        logic [2:0]   id;
    } wb_t;

    pkt_t         hist[$];
    wb_t          wb_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           last_reset = -10;
    bit           mon_en = 1'b0;
    logic [6:0]   held_addr = '0;
    logic [0:127] held_value = '0;
    logic [2:0]   held_id = '0;

    odd_result_pipe #(.NUM_STAGES(NS), .DATA_W(128), .ADDR_W(7)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_rt_value(in_rt_value),
        .in_rt_addr(in_rt_addr), .in_reg_write(in_reg_write), .in_unit_latency(in_unit_latency),
        .in_unit_id(in_unit_id), .flush(flush), .fwd_query_addr(fwd_query_addr),
        .fwd_hit(fwd_hit), .fwd_value(fwd_value), .fwd_pending(fwd_pending),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_value(wb_value),
        .wb_unit_id(wb_unit_id), .in_flight(in_flight)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record what the model expects from them.
    task automatic apply_stimulus(input bit v, input logic [6:0] addr, input logic [0:127] val,
                                  input bit wr, input logic [3:0] lat, input logic [2:0] id,
                                  input bit fl, input logic [6:0] q, input bit rst);
        pkt_t p;
        wb_t  w;
        reset = rst; in_valid = v; in_rt_addr = addr; in_rt_value = val; in_reg_write = wr;
        in_unit_latency = lat; in_unit_id = id; flush = fl; fwd_query_addr = q;
        while (hist.size() > 0 && cyc - hist[0].issue > NS + 2) void'(hist.pop_front());
        if (rst) begin
            foreach (hist[i]) if (hist[i].killed > cyc) hist[i].killed = cyc;
            while (wb_q.size() > 0 && wb_q[$].due > cyc) void'(wb_q.pop_back());
            last_reset = cyc;
        end else if (v && !fl) begin
            p.issue = cyc; p.killed = BIG; p.addr = addr; p.value = val; p.wr = wr;
            p.lat = (lat == 0) ? 1 : ((int'(lat) > NS) ? NS : int'(lat));
            hist.push_back(p);
            if (wr) begin
                w.due = cyc + NS + 1; w.addr = addr; w.value = val; w.id = id;
                wb_q.push_back(w);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic [6:0] q);
        for (int i = 0; i < n; i++) apply_stimulus(0, '0, '0, 0, '0, '0, 0, q, 0);
    endtask

    task automatic check_output();
        int           now;
        int           best_age;
        int           bi;
        int           age;
        int           cnt;
        bit           exp_wb;
        bit           ready;
        logic [0:127] exp_val;
        wb_t          e;
        now = cyc;
        if (now == last_reset + 1) begin
            held_addr = '0; held_value = '0; held_id = '0;
        end
        exp_wb = (wb_q.size() > 0 && wb_q[0].due == now);
        check("wb_valid", 128'(wb_valid), 128'(exp_wb));
        if (exp_wb) begin
            e = wb_q.pop_front();
            held_addr = e.addr; held_value = e.value; held_id = e.id;
        end
        check("wb_addr", 128'(wb_addr), 128'(held_addr));
        check("wb_value", wb_value, held_value);
        check("wb_unit_id", 128'(wb_unit_id), 128'(held_id));

        best_age = 0; bi = 0; cnt = 0;
        foreach (hist[i]) begin
            age = now - hist[i].issue;
            if (age >= 1 && age <= NS && now <= hist[i].killed) begin
                cnt++;
                if (hist[i].wr && hist[i].addr == fwd_query_addr && (best_age == 0 || age < best_age)) begin
                    best_age = age; bi = i;
                end
            end
        end
        ready   = (best_age != 0) && (best_age >= hist[bi].lat);
        exp_val = ready ? hist[bi].value : '0;
        check("fwd_hit", 128'(fwd_hit), 128'(ready));
        check("fwd_pending", 128'(fwd_pending), 128'((best_age != 0) && !ready));
        check("fwd_value", fwd_value, exp_val);
        check("in_flight", 128'(in_flight), 128'(cnt));
    endtask

    always @(negedge clock) if (mon_en) check_output();

    initial begin
        logic [0:127] v;
        bit           rv;
        bit           rf;
        bit           rr;
        reset = 1; in_valid = 0; in_rt_value = '0; in_rt_addr = '0; in_reg_write = 0;
        in_unit_latency = '0; in_unit_id = '0; flush = 0; fwd_query_addr = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_wb_valid", 128'(wb_valid), 128'(0));
        check("rst_wb_addr", 128'(wb_addr), 128'(0));
        check("rst_wb_value", wb_value, 128'(0));
        check("rst_wb_unit_id", 128'(wb_unit_id), 128'(0));
        check("rst_in_flight", 128'(in_flight), 128'(0));
        check("rst_fwd_hit", 128'(fwd_hit), 128'(0));
        reset = 0;
        mon_en = 1;
        idle(2, 7'd10);

        $display("[TB] single op");
        apply_stimulus(1, 7'd10, 128'h0123456789ABCDEF0123456789ABCDEF, 1, 4'd4, 3'd5, 0, 7'd10, 0);
        idle(10, 7'd10);

        $display("[TB] same address twice");
        apply_stimulus(1, 7'd20, 128'd1, 1, 4'd4, 3'd5, 0, 7'd20, 0);
        idle(4, 7'd20);
        apply_stimulus(1, 7'd20, 128'd2, 1, 4'd4, 3'd5, 0, 7'd20, 0);
        idle(10, 7'd20);

        $display("[TB] flush");
        apply_stimulus(1, 7'd30, 128'hAAAA, 1, 4'd4, 3'd5, 0, 7'd30, 0);
        apply_stimulus(1, 7'd31, 128'hBBBB, 1, 4'd4, 3'd5, 1, 7'd31, 0);
        idle(10, 7'd30);

        $display("[TB] latency edges");
        apply_stimulus(1, 7'd40, 128'h40, 1, 4'd0, 3'd1, 0, 7'd40, 0);
        idle(9, 7'd40);
        apply_stimulus(1, 7'd41, 128'h41, 1, 4'd15, 3'd2, 0, 7'd41, 0);
        idle(9, 7'd41);
        apply_stimulus(1, 7'd42, 128'h42, 0, 4'd4, 3'd3, 0, 7'd42, 0);
        idle(9, 7'd42);

        $display("[TB] back-to-back");
        for (int i = 0; i < 10; i++)
            apply_stimulus(1, 7'(i), 128'(i + 100), 1, 4'd4, 3'd5, 0, 7'd3, 0);
        idle(10, 7'd9);

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++)
            apply_stimulus(1, 7'd50, 128'(i + 500), 1, 4'd1, 3'd5, 0, 7'd50, 0);
        apply_stimulus(1, 7'd50, 128'h77, 1, 4'd1, 3'd5, 1, 7'd50, 1);
        idle(10, 7'd50);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            v  = {$urandom, $urandom, $urandom, $urandom};
            rv = ($urandom_range(0, 9) < 7);
            rf = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 99) == 0);
            apply_stimulus(rv, 7'($urandom_range(0, 7)), v, ($urandom_range(0, 9) < 8),
                           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rf,
                           7'($urandom_range(0, 7)), rr);
        end
        idle(12, 7'd0);
        check("drain", 128'(wb_q.size()), 128'(0));

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
